// File: rtl/mem_access_stage_pkg.sv
// Shared types and sizing for the memory-access pipeline stage.
// Holds the FSM state encoding, the default ack timeout and the datapath widths.
// Imported by the interface, the wait timer and the stage itself.
package mem_access_stage_pkg;

  localparam int DATA_W      = 16;
  localparam int REG_W       = 3;
  localparam int CNT_W       = 8;
  // Cycles waited for an ack before the request is abandoned (legal 1..255).
  localparam int TIMEOUT_DEF = 15;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/ack bus between the memory-access stage and the data memory.
// The stage (master) holds memReq plus address/data until memAck or timeout.
// The memory (slave) answers with memAck, and memRdata for loads.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic  memReq;
  logic  memWe;
  data_t memAddr;
  data_t memWdata;
  logic  memAck;
  data_t memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memAck, memRdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory ack and flags when the limit is hit.
// Latency: expired is a pure compare on the registered count (same cycle).
// No backpressure; clear has priority over count.
module mem_wait_timer
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  cnt_t cnt_q;

  // Wait counter: restart on entry to a wait, advance on each un-acked wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  // The stage never counts past the limit, so equality also means "not below".
  assign expired = (cnt_q == cnt_t'(TIMEOUT));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores, forwards ALU results to write-back.
// Latency: ALU results 1 cycle; loads 1 cycle after memAck; aborts after TIMEOUT wait cycles.
// Backpressure: combinational stall holds upstream while a request is issued or pending.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  data_t aluOutput,
  input  logic  writeRegp3,
  input  reg_t  regAddressp3,
  input  data_t Address,
  input  data_t storeData,
  input  logic  readEnable,
  input  logic  writeEnable,
  input  logic  pcsrc,
  input  data_t pctarget,
  mem_access_stage_if.master mem,
  output logic  wbEnable,
  output reg_t  wbAddr,
  output data_t wbData,
  output logic  stall,
  output logic  pcsrcOut,
  output data_t pctargetOut,
  output logic  memFault,
  output data_t faultAddr
);

  state_t state_q, state_nxt;
  logic   issue_rd, issue_wr, done, abort;
  logic   tmr_clear, tmr_count, expired;
  logic   lat_wr;
  reg_t   lat_addr;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (expired)
  );

  // State register; reset lands in IDLE and drops any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state and per-cycle control strobes. Ack beats the timeout in the same cycle.
  always_comb begin
    state_nxt = state_q;
    stall     = 1'b0;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    tmr_clear = 1'b0;
    tmr_count = 1'b0;
    case (state_q)
      IDLE: begin
        if (writeEnable) begin
          issue_wr  = 1'b1;
          stall     = 1'b1;
          tmr_clear = 1'b1;
          state_nxt = WR_WAIT;
        end else if (readEnable) begin
          issue_rd  = 1'b1;
          stall     = 1'b1;
          tmr_clear = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem.memAck) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall     = 1'b1;
          tmr_count = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: memory request, write-back, branch forwarding and sticky fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.memReq   <= 1'b0;
      mem.memWe    <= 1'b0;
      mem.memAddr  <= '0;
      mem.memWdata <= '0;
      wbEnable     <= 1'b0;
      wbAddr       <= '0;
      wbData       <= '0;
      pcsrcOut     <= 1'b0;
      pctargetOut  <= '0;
      memFault     <= 1'b0;
      faultAddr    <= '0;
      lat_wr       <= 1'b0;
      lat_addr     <= '0;
    end else begin
      pcsrcOut    <= pcsrc & ~stall;
      pctargetOut <= pctarget;
      if (issue_wr) begin
        mem.memReq   <= 1'b1;
        mem.memWe    <= 1'b1;
        mem.memAddr  <= Address;
        mem.memWdata <= storeData;
        wbEnable     <= 1'b0;
      end else if (issue_rd) begin
        mem.memReq  <= 1'b1;
        mem.memWe   <= 1'b0;
        mem.memAddr <= Address;
        lat_wr      <= writeRegp3;
        lat_addr    <= regAddressp3;
        wbEnable    <= 1'b0;
      end else if (state_q == IDLE) begin
        wbEnable <= writeRegp3;
        wbAddr   <= regAddressp3;
        wbData   <= aluOutput;
      end else if (done) begin
        mem.memReq <= 1'b0;
        mem.memWe  <= 1'b0;
        if (state_q == RD_WAIT) begin
          wbEnable <= lat_wr;
          wbAddr   <= lat_addr;
          wbData   <= mem.memRdata;
        end else begin
          wbEnable <= 1'b0;
        end
      end else if (abort) begin
        mem.memReq <= 1'b0;
        mem.memWe  <= 1'b0;
        wbEnable   <= 1'b0;
        memFault   <= 1'b1;
        if (!memFault) faultAddr <= mem.memAddr;
      end else begin
        wbEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with TIMEOUT=4.
// Expected values come from the stage's transaction rules (cycle counts per op).
// Random ALU, load, store and timeout ops are mixed after the directed cases.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic [15:0] aluOutput, Address, storeData, pctarget;
  logic        writeRegp3, readEnable, writeEnable, pcsrc;
  logic [2:0]  regAddressp3;
  logic        wbEnable, stall, pcsrcOut, memFault;
  logic [2:0]  wbAddr;
  logic [15:0] wbData, pctargetOut, faultAddr;

  int checks = 0;
  int errors = 0;
  bit          fault_exp = 1'b0;
  logic [15:0] fault_addr_exp = 16'h0;

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .aluOutput    (aluOutput),
    .writeRegp3   (writeRegp3),
    .regAddressp3 (regAddressp3),
    .Address      (Address),
    .storeData    (storeData),
    .readEnable   (readEnable),
    .writeEnable  (writeEnable),
    .pcsrc        (pcsrc),
    .pctarget     (pctarget),
    .mem          (mif),
    .wbEnable     (wbEnable),
    .wbAddr       (wbAddr),
    .wbData       (wbData),
    .stall        (stall),
    .pcsrcOut     (pcsrcOut),
    .pctargetOut  (pctargetOut),
    .memFault     (memFault),
    .faultAddr    (faultAddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    aluOutput = '0; Address = '0; storeData = '0; pctarget = '0;
    writeRegp3 = 1'b0; readEnable = 1'b0; writeEnable = 1'b0; pcsrc = 1'b0;
    regAddressp3 = '0; mif.memAck = 1'b0; mif.memRdata = '0;
    #12;
    checks++;
    if (mif.memReq !== 1'b0) begin
      errors++; $display("FAIL reset_memReq: got %b want 0", mif.memReq);
    end
    checks++;
    if ({mif.memWe, mif.memAddr, mif.memWdata, wbEnable, wbAddr, wbData, stall,
         pcsrcOut, pctargetOut, memFault, faultAddr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h wbe=%b wba=%h wbd=%h st=%b pc=%b pct=%h flt=%b fa=%h want all 0",
               mif.memWe, mif.memAddr, mif.memWdata, wbEnable, wbAddr, wbData, stall,
               pcsrcOut, pctargetOut, memFault, faultAddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fault_exp = 1'b0;
    fault_addr_exp = '0;
  endtask

  // One cycle of a register-only op; memAck/memRdata are randomised to show they are ignored.
  task automatic alu_op(input logic [15:0] a, input bit wreg, input logic [2:0] ra);
    logic        pc_exp;
    logic [15:0] pct_exp;
    aluOutput = a; writeRegp3 = wreg; regAddressp3 = ra;
    readEnable = 1'b0; writeEnable = 1'b0;
    Address = 16'($urandom); storeData = 16'($urandom);
    pc_exp = 1'($urandom_range(0, 1)); pct_exp = 16'($urandom);
    pcsrc = pc_exp; pctarget = pct_exp;
    mif.memAck = 1'($urandom_range(0, 1)); mif.memRdata = 16'($urandom);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL alu_stall: got %b want 0", stall);
    end
    step();
    checks++;
    if (wbEnable !== wreg || wbAddr !== ra || wbData !== a) begin
      errors++;
      $display("FAIL alu_wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
               wbEnable, wbAddr, wbData, wreg, ra, a);
    end
    checks++;
    if (mif.memReq !== 1'b0 || pcsrcOut !== pc_exp || pctargetOut !== pct_exp) begin
      errors++;
      $display("FAIL alu_ctrl: got req=%b pc=%b pct=%h want req=0 pc=%b pct=%h",
               mif.memReq, pcsrcOut, pctargetOut, pc_exp, pct_exp);
    end
  endtask

  // Memory op held by upstream. k = the memReq-high cycle in which memAck arrives (1..TO+1);
  // k = 0 means no ack ever, so the request is abandoned after TO+1 cycles.
  task automatic mem_op(input bit wr, input int k, input logic [15:0] addr, input logic [15:0] d,
                        input bit wreg, input logic [2:0] ra, input string nm);
    int          hold;
    bit          es, ewb;
    logic [15:0] pct;
    hold = (k == 0) ? TO + 1 : k;
    pct  = 16'($urandom);
    writeEnable = wr;
    readEnable  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    Address = addr; storeData = wr ? d : 16'($urandom);
    aluOutput = 16'($urandom); writeRegp3 = wreg; regAddressp3 = ra;
    pcsrc = 1'b1; pctarget = pct;
    mif.memAck = 1'($urandom_range(0, 1)); mif.memRdata = 16'($urandom);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL %s_issue_stall: got %b want 1", nm, stall);
    end
    for (int c = 1; c <= hold; c++) begin
      step();
      checks++;
      if (mif.memReq !== 1'b1 || mif.memWe !== wr || mif.memAddr !== addr ||
          (wr && mif.memWdata !== d) || wbEnable !== 1'b0) begin
        errors++;
        $display("FAIL %s_wait%0d: got req=%b we=%b addr=%h wd=%h wbe=%b want req=1 we=%b addr=%h wd=%h wbe=0",
                 nm, c, mif.memReq, mif.memWe, mif.memAddr, mif.memWdata, wbEnable, wr, addr, d);
      end
      if (c == 1) begin
        checks++;
        if (pcsrcOut !== 1'b0) begin
          errors++; $display("FAIL %s_pcsrc_stalled: got %b want 0", nm, pcsrcOut);
        end
      end
      if (c == k) begin
        mif.memAck = 1'b1; mif.memRdata = wr ? 16'($urandom) : d;
      end else begin
        mif.memAck = 1'b0; mif.memRdata = 16'($urandom);
      end
      #1;
      es = (c != k) && (c - 1 < TO);
      checks++;
      if (stall !== es) begin
        errors++; $display("FAIL %s_stall%0d: got %b want %b", nm, c, stall, es);
      end
    end
    step();
    if (k == 0) begin
      if (!fault_exp) fault_addr_exp = addr;
      fault_exp = 1'b1;
    end
    ewb = (k != 0) && !wr && wreg;
    checks++;
    if (mif.memReq !== 1'b0 || mif.memWe !== 1'b0 || wbEnable !== ewb ||
        (ewb && (wbAddr !== ra || wbData !== d))) begin
      errors++;
      $display("FAIL %s_end: got req=%b we=%b wbe=%b wba=%0d wbd=%h want req=0 we=0 wbe=%b wba=%0d wbd=%h",
               nm, mif.memReq, mif.memWe, wbEnable, wbAddr, wbData, ewb, ra, d);
    end
    checks++;
    if (memFault !== fault_exp || (fault_exp && faultAddr !== fault_addr_exp)) begin
      errors++;
      $display("FAIL %s_fault: got flt=%b fa=%h want flt=%b fa=%h",
               nm, memFault, faultAddr, fault_exp, fault_addr_exp);
    end
    checks++;
    if (pcsrcOut !== 1'b1 || pctargetOut !== pct) begin
      errors++;
      $display("FAIL %s_pc_release: got pc=%b pct=%h want pc=1 pct=%h", nm, pcsrcOut, pctargetOut, pct);
    end
    readEnable = 1'b0; writeEnable = 1'b0; writeRegp3 = 1'b0; mif.memAck = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL %s_post_stall: got %b want 0", nm, stall);
    end
    step();
    checks++;
    if (mif.memReq !== 1'b0) begin
      errors++; $display("FAIL %s_no_reissue: got req=%b want 0", nm, mif.memReq);
    end
  endtask

  task automatic test_alu();
    alu_op(16'h1234, 1'b1, 3'd5);
    for (int i = 0; i < 5; i++)
      alu_op(16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
  endtask

  task automatic test_load();
    mem_op(1'b0, 3, 16'h0040, 16'hBEEF, 1'b1, 3'd2, "load");
    mem_op(1'b0, 1, 16'($urandom), 16'($urandom), 1'b1, 3'($urandom_range(0, 7)), "load_fast");
  endtask

  task automatic test_store();
    mem_op(1'b1, 1, 16'h0010, 16'h00FF, 1'b1, 3'd3, "store");
    mem_op(1'b1, 3, 16'($urandom), 16'($urandom), 1'b0, 3'd0, "store_slow");
  endtask

  task automatic test_ack_on_expiry();
    mem_op(1'b0, TO + 1, 16'h0300, 16'h5A5A, 1'b1, 3'd6, "ack_expiry_ld");
    mem_op(1'b1, TO + 1, 16'h0304, 16'hA5A5, 1'b0, 3'd0, "ack_expiry_st");
  endtask

  task automatic test_timeout();
    mem_op(1'b0, 0, 16'h0200, 16'h0000, 1'b1, 3'd1, "timeout");
    alu_op(16'hCAFE, 1'b1, 3'd7);
    mem_op(1'b1, 0, 16'h0400, 16'h1111, 1'b0, 3'd0, "timeout_again");
  endtask

  task automatic test_back_to_back();
    int op;
    for (int i = 0; i < 20; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0:       alu_op(16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        1, 2:    mem_op(1'b0, int'($urandom_range(1, TO + 1)), 16'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rnd_load");
        3:       mem_op(1'b1, int'($urandom_range(1, TO + 1)), 16'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rnd_store");
        default: mem_op(1'($urandom_range(0, 1)), 0, 16'($urandom), 16'($urandom),
                        1'b1, 3'($urandom_range(0, 7)), "rnd_timeout");
      endcase
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] a;
    readEnable = 1'b1; writeEnable = 1'b0; Address = 16'h0840;
    writeRegp3 = 1'b1; regAddressp3 = 3'd4; mif.memAck = 1'b0;
    step();
    step();
    checks++;
    if (mif.memReq !== 1'b1) begin
      errors++; $display("FAIL rstmid_pending: got req=%b want 1", mif.memReq);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mif.memReq !== 1'b0 || wbEnable !== 1'b0 || memFault !== 1'b0 || faultAddr !== 16'h0 ||
        mif.memAddr !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_async: got req=%b wbe=%b flt=%b fa=%h addr=%h want all 0",
               mif.memReq, wbEnable, memFault, faultAddr, mif.memAddr);
    end
    fault_exp = 1'b0; fault_addr_exp = '0;
    a = 16'($urandom);
    readEnable = 1'b0; aluOutput = a; regAddressp3 = 3'd6;
    mif.memAck = 1'b1; mif.memRdata = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (mif.memReq !== 1'b0 || wbEnable !== 1'b1 || wbAddr !== 3'd6 || wbData !== a) begin
      errors++;
      $display("FAIL rstmid_idle: got req=%b wbe=%b wba=%0d wbd=%h want req=0 wbe=1 wba=6 wbd=%h",
               mif.memReq, wbEnable, wbAddr, wbData, a);
    end
    mif.memAck = 1'b0;
    mem_op(1'b0, 2, 16'h0900, 16'h7777, 1'b1, 3'd2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_on_expiry();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
